// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// IMEM_ADDR_W is the same word-address width the fetch stage slices from the PC.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 12;
  localparam int HDR_BYTES   = 4;
  localparam int WORD_BYTES  = 4;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer shared by the header count and data words.
// word_o/word_done_o are combinational and valid in the cycle of the last byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  localparam int PACK_BYTES =
    (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;
  localparam logic [1:0] LAST = 2'(PACK_BYTES - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sh_q, sh_d;

  assign word_o      = {byte_i, sh_q};
  assign word_done_o = byte_en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (byte_en) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = {byte_i, sh_q[23:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a counted, little-endian program image into instruction memory
// and holds the core in reset until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [32:0] CAP = 33'(1) << ADDR_W;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        byte_en;
  logic        rearm;
  logic [31:0] word;
  logic        word_done;

  assign byte_en = in_valid && in_ready;
  assign rearm   = load_req &&
                   (state_q == S_DONE || state_q == S_ERROR);

  imem_loader_byte_packer u_pack (
    .clk         (clk),
    .rst         (rst),
    .clr         (rearm),
    .byte_en     (byte_en),
    .byte_i      (in_data),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_HDR;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR: begin
        if (word_done) begin
          if (word == 32'd0)
            state_d = S_DONE;
          else if ({1'b0, word} > CAP)
            state_d = S_ERROR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_done && idx_q == last_q)
          state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  if (load_req) state_d = S_HDR;
      S_ERROR: if (load_req) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    unique case (1'b1)
      (state_q == S_HDR),
      (state_q == S_DATA): in_ready = 1'b1;
      (state_q == S_DONE): begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      (state_q == S_ERROR): err = 1'b1;
      default: ;
    endcase
  end

  // last_q holds count-1 so a full 2^ADDR_W load ends at the top index
  always_comb begin
    idx_d   = idx_q;
    last_d  = last_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (rearm) idx_d = '0;
    if (word_done && state_q == S_HDR) begin
      last_d = word[ADDR_W-1:0] - ADDR_W'(1);
      idx_d  = '0;
    end
    if (word_done && state_q == S_DATA) begin
      we_d    = 1'b1;
      addr_d  = idx_q;
      wdata_d = word;
      idx_d   = idx_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q   <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      idx_q   <= idx_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a byte-count model checked every cycle.
// Literal expectations pin the model on key words, timings and counts.
module tb_imem_loader;

  localparam int AW = 12;
  localparam logic [32:0] CAP = 33'(1) << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          load_req = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;
  bit abort  = 0;

  int          m_nb = 0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_wbuf = '0;
  bit          m_known, m_done, m_err, m_pend, m_we;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          started = 0;

  logic [31:0] wlog [0:(1<<AW)-1];
  int          wr_count = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s t=%0t got=%h want=%h", n, $time, a, e);
    end
  endtask

  function automatic bit m_ready();
    if (m_nb < 4) return 1'b1;
    if (!m_known || m_cnt == 0) return 1'b0;
    if ({1'b0, m_cnt} > CAP) return 1'b0;
    return m_nb < 4 + 4 * int'(m_cnt);
  endfunction

  initial forever begin
    bit v, r, lr, rdy, was_done, was_err;
    logic [7:0] d;
    int k, j;
    @(posedge clk);
    v = in_valid; d = in_data; r = rst; lr = load_req;
    rdy = m_ready(); was_done = m_done; was_err = m_err;
    if (!r) begin
      m_nb = 0; m_known = 0; m_done = 0; m_err = 0;
      m_pend = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      started = 1;
    end else begin
      m_we = 0;
      if (m_pend) begin m_done = 1; m_pend = 0; end
      if (lr && (was_done || was_err)) begin
        m_nb = 0; m_known = 0; m_done = 0; m_err = 0;
      end else if (v && rdy) begin
        if (m_nb < 4) begin
          m_cnt[8*m_nb +: 8] = d;
          m_nb++;
          if (m_nb == 4) begin
            m_known = 1;
            if (m_cnt == 0) m_done = 1;
            else if ({1'b0, m_cnt} > CAP) m_err = 1;
          end
        end else begin
          k = (m_nb - 4) / 4;
          j = (m_nb - 4) % 4;
          m_wbuf[8*j +: 8] = d;
          m_nb++;
          if (j == 3) begin
            m_we = 1;
            m_addr = k[AW-1:0];
            m_wdata = m_wbuf;
            if (m_nb == 4 + 4 * int'(m_cnt)) m_pend = 1;
          end
        end
      end
    end
    #1;
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("imem_we", 32'(imem_we), 32'(m_we));
      chk("imem_addr", 32'(imem_addr), 32'(m_addr));
      chk("imem_wdata", imem_wdata, m_wdata);
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("cpu_hold", 32'(cpu_hold), 32'(!m_done));
      if (imem_we === 1'b1) begin
        wlog[imem_addr] = imem_wdata;
        wr_count++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    if (abort) return;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      checks++;
      errors++;
      $display("FAIL send_timeout t=%0t got=stalled want=ready", $time);
      in_valid = 1'b0;
      abort = 1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gmax);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_load();
    @(negedge clk);
    in_valid = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int base;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // 8 words back to back
    send_word(32'd8, 0);
    for (int i = 0; i < 8; i++) begin
      w = (i == 0) ? 32'h0000_0013 : 32'h00A0_0093 + 32'(i);
      send_word(w, 0);
    end
    idle(1);
    chk("t1_last_we", 32'(imem_we), 32'd1);
    chk("t1_done_early", 32'(done), 32'd0);
    idle(1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    chk("t1_writes", 32'(wr_count), 32'd8);
    chk("t1_w0", wlog[0], 32'h0000_0013);
    chk("t1_w7", wlog[7], 32'h00A0_009A);

    // zero length, then offer bytes while not ready
    pulse_load();
    chk("rearm_done", 32'(done), 32'd0);
    send_word(32'd0, 0);
    idle(1);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("t2_writes", 32'(wr_count), 32'd8);

    // oversize count
    pulse_load();
    send_word(32'h0000_1001, 0);
    idle(1);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_hold", 32'(cpu_hold), 32'd1);
    chk("t3_ready", 32'(in_ready), 32'd0);
    pulse_load();
    chk("t3_err_clr", 32'(err), 32'd0);
    chk("t3_hdr", 32'(in_ready), 32'd1);

    // three words with random stalls
    send_word(32'd3, 0);
    send_word(32'h0010_0093, 3);
    send_word(32'h0020_0113, 3);
    send_word(32'h0030_81B3, 3);
    idle(3);
    chk("t4_w0", wlog[0], 32'h0010_0093);
    chk("t4_w1", wlog[1], 32'h0020_0113);
    chk("t4_w2", wlog[2], 32'h0030_81B3);
    chk("t4_writes", 32'(wr_count), 32'd11);

    // reset in the middle of word 1
    pulse_load();
    base = wr_count;
    send_word(32'd3, 0);
    send_word(32'h1111_1111, 0);
    send_byte(8'h22);
    send_byte(8'h22);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t5_we_after_rst", 32'(imem_we), 32'd0);
    chk("t5_hdr", 32'(in_ready), 32'd1);
    idle(3);
    chk("t5_writes", 32'(wr_count - base), 32'd1);
    send_word(32'd1, 0);
    send_word(32'hDEAD_BEEF, 0);
    idle(3);
    chk("t5_w0", wlog[0], 32'hDEAD_BEEF);
    chk("t5_done", 32'(done), 32'd1);

    // full capacity
    pulse_load();
    base = wr_count;
    send_word(32'(1 << AW), 0);
    for (int i = 0; i < (1 << AW); i++)
      send_word(32'hA500_0000 | 32'(i), 0);
    idle(3);
    chk("t6_writes", 32'(wr_count - base), 32'd4096);
    chk("t6_first", wlog[0], 32'hA500_0000);
    chk("t6_last", wlog[4095], 32'hA500_0FFF);
    chk("t6_done", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
